sc_mem_access_ctrl: RTL and testbench

//   Main-memory access sequencer directly downstream of the microprogrammed control unit.
//   - Consumes the MIR RD/WR strobes plus the address and store data from the datapath.
//   - Runs a req/ack handshake with main memory and returns load data to the datapath.
//   - Asserts a stall that freezes CSAI/MIR until the access completes, times out or is rejected.

---
 rtl/sc_mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sc_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_mem_access_ctrl.sv
// Main-memory access sequencer: turns MIR RD/WR strobes into a req/ack memory
// transaction, stalls the control unit meanwhile and reports timeout/alignment/conflict errors.
module sc_mem_access_ctrl #(
    parameter int unsigned DATAWIDTH_BUS  = 32,
    parameter int unsigned DATAWIDTH_ADDR = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      SC_MemCtrl_CLOCK_50,
    input  logic                      SC_MemCtrl_RESET_InHigh,
    input  logic                      SC_MemCtrl_RD_In,
    input  logic                      SC_MemCtrl_WR_In,
    input  logic [DATAWIDTH_ADDR-1:0] SC_MemCtrl_Addr_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]  SC_MemCtrl_WData_InBUS,
    input  logic                      SC_MemCtrl_ErrClear_In,
    input  logic [DATAWIDTH_BUS-1:0]  SC_MemCtrl_MemRData_InBUS,
    input  logic                      SC_MemCtrl_MemAck_In,
    output logic                      SC_MemCtrl_MemReq_Out,
    output logic                      SC_MemCtrl_MemWE_Out,
    output logic [DATAWIDTH_ADDR-1:0] SC_MemCtrl_MemAddr_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]  SC_MemCtrl_MemWData_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]  SC_MemCtrl_RData_OutBUS,
    output logic                      SC_MemCtrl_Stall_Out,
    output logic                      SC_MemCtrl_Done_Out,
    output logic                      SC_MemCtrl_Error_Out,
    output logic [1:0]                SC_MemCtrl_ErrCode_OutBUS
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t                    r_state, w_state_next;
    logic [CNT_W-1:0]          r_cnt, w_cnt_next;
    logic                      r_req, w_req_next;
    logic                      r_we, w_we_next;
    logic [DATAWIDTH_ADDR-1:0] r_addr, w_addr_next;
    logic [DATAWIDTH_BUS-1:0]  r_wdata, w_wdata_next;
    logic [DATAWIDTH_BUS-1:0]  r_rdata, w_rdata_next;
    logic                      r_done, w_done_next;
    logic                      r_err, w_err_next;
    logic [1:0]                r_code, w_code_next;
    logic                      w_start;

    assign w_start = SC_MemCtrl_RD_In | SC_MemCtrl_WR_In;

    always_ff @(posedge SC_MemCtrl_CLOCK_50) begin
        if (SC_MemCtrl_RESET_InHigh) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_req   <= w_req_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_rdata <= w_rdata_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_code  <= w_code_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_req_next   = r_req;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rdata_next = r_rdata;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        w_code_next  = r_code;

        // Clear first so an error raised below in the same cycle takes precedence.
        if (SC_MemCtrl_ErrClear_In) begin
            w_err_next  = 1'b0;
            w_code_next = 2'b00;
        end

        case (r_state)
            StIdle: begin
                if (w_start) begin
                    if (SC_MemCtrl_RD_In && SC_MemCtrl_WR_In) begin
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_CONFLICT;
                        w_done_next  = 1'b1;
                        w_state_next = StDone;
                    end else if (SC_MemCtrl_Addr_InBUS[1:0] != 2'b00) begin
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_MISALIGN;
                        w_done_next  = 1'b1;
                        w_state_next = StDone;
                    end else begin
                        w_addr_next  = SC_MemCtrl_Addr_InBUS;
                        w_wdata_next = SC_MemCtrl_WData_InBUS;
                        w_we_next    = SC_MemCtrl_WR_In;
                        w_req_next   = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                // Ack is checked before the timeout, so a last-cycle ack still succeeds.
                if (SC_MemCtrl_MemAck_In) begin
                    w_req_next = 1'b0;
                    if (!r_we) begin
                        w_rdata_next = SC_MemCtrl_MemRData_InBUS;
                    end
                    w_done_next  = 1'b1;
                    w_state_next = StDone;
                end else if (r_cnt == CNT_LAST) begin
                    w_req_next   = 1'b0;
                    w_err_next   = 1'b1;
                    w_code_next  = ERR_TIMEOUT;
                    w_done_next  = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
                w_req_next   = 1'b0;
            end
        endcase
    end

    assign SC_MemCtrl_MemReq_Out      = r_req;
    assign SC_MemCtrl_MemWE_Out       = r_we;
    assign SC_MemCtrl_MemAddr_OutBUS  = r_addr;
    assign SC_MemCtrl_MemWData_OutBUS = r_wdata;
    assign SC_MemCtrl_RData_OutBUS    = r_rdata;
    assign SC_MemCtrl_Done_Out        = r_done;
    assign SC_MemCtrl_Error_Out       = r_err;
    assign SC_MemCtrl_ErrCode_OutBUS  = r_code;
    assign SC_MemCtrl_Stall_Out       = (r_state == StWait) || ((r_state == StIdle) && w_start);

endmodule

// File: tb/tb_sc_mem_access_ctrl.sv
// Directed self-checking bench for sc_mem_access_ctrl: reads, writes, timeout, error
// paths, reset mid-access and back-to-back reads.
module tb_sc_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, errclr, ack;
    logic [31:0] addr, wdata, mrdata;
    logic        req, we, stall, done, err;
    logic [31:0] maddr, mwdata, rdata;
    logic [1:0]  code;

    int n_total = 0;
    int n_bad   = 0;

    // Per-access observations filled by run_acc.
    int   g_stall, g_req, g_done, g_done_at;
    logic g_stable, g_we;

    always #5 clk = ~clk;

    sc_mem_access_ctrl #(
        .DATAWIDTH_BUS (32),
        .DATAWIDTH_ADDR(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .SC_MemCtrl_CLOCK_50       (clk),
        .SC_MemCtrl_RESET_InHigh   (rst),
        .SC_MemCtrl_RD_In          (rd),
        .SC_MemCtrl_WR_In          (wr),
        .SC_MemCtrl_Addr_InBUS     (addr),
        .SC_MemCtrl_WData_InBUS    (wdata),
        .SC_MemCtrl_ErrClear_In    (errclr),
        .SC_MemCtrl_MemRData_InBUS (mrdata),
        .SC_MemCtrl_MemAck_In      (ack),
        .SC_MemCtrl_MemReq_Out     (req),
        .SC_MemCtrl_MemWE_Out      (we),
        .SC_MemCtrl_MemAddr_OutBUS (maddr),
        .SC_MemCtrl_MemWData_OutBUS(mwdata),
        .SC_MemCtrl_RData_OutBUS   (rdata),
        .SC_MemCtrl_Stall_Out      (stall),
        .SC_MemCtrl_Done_Out       (done),
        .SC_MemCtrl_Error_Out      (err),
        .SC_MemCtrl_ErrCode_OutBUS (code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge. ack_k = WAIT cycle carrying ack (0 = never acked).
    task automatic run_acc(input logic a_rd, input logic a_wr, input logic [31:0] a_addr,
                           input logic [31:0] a_wdata, input int ack_k,
                           input logic [31:0] a_mrdata, input logic clr_first);
        int   w;
        logic fin;
        w = 0;
        fin = 1'b0;
        g_stall = 0; g_req = 0; g_done = 0; g_done_at = -1;
        g_stable = 1'b1; g_we = 1'b0;
        rd = a_rd; wr = a_wr; addr = a_addr; wdata = a_wdata; mrdata = a_mrdata;
        errclr = clr_first;
        for (int i = 0; i < 40 && !fin; i++) begin
            #1;
            if (stall) g_stall++;
            if (req) begin
                g_req++;
                w++;
                g_we = we;
                if (maddr !== a_addr || mwdata !== a_wdata) g_stable = 1'b0;
            end
            ack = req && (w == ack_k);
            if (done) begin
                g_done++;
                g_done_at = i;
                rd = 1'b0;
                wr = 1'b0;
                fin = 1'b1;
            end
            @(negedge clk);
            errclr = 1'b0;
        end
        ack = 1'b0;
        check("acc_finished", {31'd0, fin}, 32'd1);
    endtask

    initial begin
        int nd, req2_at, st3;
        logic prev_req;
        rst = 1'b1; rd = 0; wr = 0; errclr = 0; ack = 0;
        addr = 0; wdata = 0; mrdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req",   {31'd0, req},   32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_err",   {29'd0, err, code}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_maddr", maddr, 32'd0);
        @(negedge clk);

        // Read, ack in first WAIT cycle.
        run_acc(1, 0, 32'h0000_0800, 32'h0, 1, 32'hDEAD_BEEF, 0);
        check("rd1_stall",  g_stall, 2);
        check("rd1_req",    g_req, 1);
        check("rd1_we",     {31'd0, g_we}, 0);
        check("rd1_doneat", g_done_at, 2);
        check("rd1_rdata",  rdata, 32'hDEAD_BEEF);
        check("rd1_err",    {31'd0, err}, 0);

        // Write, ack in third WAIT cycle; RData must not move.
        run_acc(0, 1, 32'h10, 32'h1234_5678, 3, 32'hFFFF_0000, 0);
        check("wr_stall",  g_stall, 4);
        check("wr_req",    g_req, 3);
        check("wr_we",     {31'd0, g_we}, 1);
        check("wr_stable", {31'd0, g_stable}, 1);
        check("wr_rdata",  rdata, 32'hDEAD_BEEF);

        // Read never acked -> timeout after 16 request cycles.
        run_acc(1, 0, 32'h20, 32'h0, 0, 32'h5555_AAAA, 0);
        check("to_req",   g_req, 16);
        check("to_stall", g_stall, 17);
        check("to_done",  g_done, 1);
        check("to_err",   {31'd0, err}, 1);
        check("to_code",  {30'd0, code}, 32'd1);
        check("to_rdata", rdata, 32'hDEAD_BEEF);
        errclr = 1'b1;
        @(negedge clk);
        errclr = 1'b0;
        #1;
        check("clr_err",  {31'd0, err}, 0);
        check("clr_code", {30'd0, code}, 0);
        @(negedge clk);

        // RD and WR together.
        run_acc(1, 1, 32'h40, 32'h0, 1, 32'h0, 0);
        check("cf_req",    g_req, 0);
        check("cf_doneat", g_done_at, 1);
        check("cf_code",   {30'd0, code}, 32'd3);
        check("cf_err",    {31'd0, err}, 1);

        // Misaligned read overwrites the sticky code.
        run_acc(1, 0, 32'h3, 32'h0, 1, 32'h0, 0);
        check("mis_req",  g_req, 0);
        check("mis_code", {30'd0, code}, 32'd2);
        check("mis_err",  {31'd0, err}, 1);

        // Access proceeds while Error is set.
        run_acc(1, 0, 32'h44, 32'h0, 2, 32'hCAFE_F00D, 0);
        check("erd_req",   g_req, 2);
        check("erd_rdata", rdata, 32'hCAFE_F00D);
        check("erd_code",  {29'd0, err, code}, 32'd6);

        // Reset in second WAIT cycle.
        rd = 1'b1; addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rw_req_before", {31'd0, req}, 1);
        rst = 1'b1; rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_req",   {31'd0, req},   0);
        check("rw_stall", {31'd0, stall}, 0);
        check("rw_done",  {31'd0, done},  0);
        check("rw_err",   {31'd0, err},   0);
        check("rw_rdata", rdata, 32'd0);
        @(negedge clk);

        // Conflict raised in the same cycle as ErrClear: the new error wins.
        run_acc(1, 1, 32'h0, 32'h0, 1, 32'h0, 1);
        check("clrw_doneat", g_done_at, 1);
        check("clrw_code",   {29'd0, err, code}, 32'd7);
        errclr = 1'b1;
        @(negedge clk);
        errclr = 1'b0;

        // Back-to-back reads, RD held through DONE.
        nd = 0; req2_at = -1; st3 = 0; prev_req = 1'b0;
        rd = 1'b1; addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i == 3) st3 = stall;
            if (req && !prev_req && nd == 1) req2_at = i;
            prev_req = req;
            ack = req;
            mrdata = 32'h1000 + i;
            if (done) begin
                nd++;
                if (nd == 2) rd = 1'b0;
            end
            @(negedge clk);
        end
        ack = 1'b0;
        check("b2b_done",    nd, 2);
        check("b2b_req2at",  req2_at, 4);
        check("b2b_stall3",  st3, 1);
        check("b2b_rdata",   rdata, 32'h1004);
        check("b2b_err",     {31'd0, err}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
